// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_access_ctrl
// Sequences MEM-stage loads/stores onto a valid/ready memory port.
// Rev    : 1.0
// ============================================================================
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        we_mem,
  input  logic [2:0]  memdata_width,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        flush,
  output logic        stall_mem,
  output logic        done,
  output logic [63:0] rdata_out,
  output logic        misalign_exc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wmask,
  input  logic        resp_valid,
  input  logic [63:0] resp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Access size as log2(bytes): 0 byte, 1 half, 2 word, 3 double.
  function automatic logic [1:0] f_size(input logic [2:0] width);
    logic [1:0] size;
    case (width)
      3'b100, 3'b111: size = 2'd0;
      3'b011, 3'b110: size = 2'd1;
      3'b010, 3'b101: size = 2'd2;
      default:        size = 2'd3;
    endcase
    return size;
  endfunction

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_width;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_drop;

  logic [1:0]  w_in_size;
  logic        w_misaligned;
  logic        w_accept;
  logic [1:0]  w_cap_size;
  logic [2:0]  w_lane;
  logic [5:0]  w_shamt;
  logic [7:0]  w_base_mask;
  logic        w_signed;
  logic [63:0] w_shifted;
  logic [63:0] w_load;

  assign w_in_size    = f_size(memdata_width);
  assign w_misaligned = ((w_in_size == 2'd1) && addr[0])
                      | ((w_in_size == 2'd2) && (addr[1:0] != 2'b00))
                      | ((w_in_size == 2'd3) && (addr[2:0] != 3'b000));
  assign w_accept     = (r_state == S_IDLE) && mem_valid && !flush;

  // rstn gating keeps these quiet while reset is held, whatever the pipeline drives.
  assign misalign_exc = rstn && w_accept && w_misaligned;
  assign stall_mem    = rstn && ((w_accept && !w_misaligned)
                              || (r_state == S_REQ) || (r_state == S_WAIT));
  assign req_valid    = (r_state == S_REQ);
  assign done         = (r_state == S_DONE);

  assign w_cap_size = f_size(r_width);
  assign w_lane     = r_addr[2:0];
  assign w_shamt    = {w_lane, 3'b000};
  assign w_signed   = (r_width == 3'b100) || (r_width == 3'b011) || (r_width == 3'b010);

  always_comb begin
    w_base_mask = 8'hFF;
    case (w_cap_size)
      2'd0:    w_base_mask = 8'h01;
      2'd1:    w_base_mask = 8'h03;
      2'd2:    w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
  end

  assign req_we    = r_we;
  assign req_addr  = {r_addr[63:3], 3'b000};
  assign req_wmask = r_we ? (w_base_mask << w_lane) : 8'h00;
  assign req_wdata = r_we ? (r_wdata << w_shamt) : 64'd0;

  assign w_shifted = resp_data >> w_shamt;

  always_comb begin
    w_load = w_shifted;
    case (w_cap_size)
      2'd0:    w_load = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    w_load = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_width   <= 3'd0;
      r_addr    <= 64'd0;
      r_wdata   <= 64'd0;
      r_drop    <= 1'b0;
      rdata_out <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_misaligned) begin
            r_we    <= we_mem;
            r_width <= memdata_width;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush)     r_drop  <= 1'b1;
          if (req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A flush landing with the response still squashes the result.
          if (resp_valid) begin
            if (r_drop || flush) begin
              r_drop  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              rdata_out <= r_we ? 64'd0 : w_load;
              r_state   <= S_DONE;
            end
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_ctrl
// Randomized self-checking bench for mem_access_ctrl against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        we_mem = 1'b0;
  logic [2:0]  memdata_width = 3'd0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic        flush = 1'b0;
  logic        stall_mem;
  logic        done;
  logic [63:0] rdata_out;
  logic        misalign_exc;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_data = 64'd0;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] m_rdata  = 64'd0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .we_mem(we_mem),
    .memdata_width(memdata_width), .addr(addr), .wdata(wdata), .flush(flush),
    .stall_mem(stall_mem), .done(done), .rdata_out(rdata_out),
    .misalign_exc(misalign_exc), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  function automatic int m_nbytes(input logic [2:0] wd);
    case (wd)
      3'b100, 3'b111: return 1;
      3'b011, 3'b110: return 2;
      3'b010, 3'b101: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic bit m_signed(input logic [2:0] wd);
    return (wd == 3'b100) || (wd == 3'b011) || (wd == 3'b010);
  endfunction

  // Load result from plain arithmetic: shift, modulo, then wrap negative values.
  function automatic logic [63:0] m_load(input logic [2:0] wd, input logic [63:0] a,
                                         input logic [63:0] rsp);
    int          nb;
    logic [63:0] v;
    logic [63:0] lim;
    nb = m_nbytes(wd);
    v  = rsp >> (8 * int'(a % 8));
    if (nb < 8) begin
      lim = 64'd1 << (8 * nb);
      v   = v % lim;
      if (m_signed(wd) && (v >= lim / 2)) v = v - lim;
    end
    return v;
  endfunction

  // fmode: 0 none, 1 flush on first REQ cycle, 2 flush on first WAIT cycle.
  task automatic run_access(input logic [2:0] wd, input logic we, input logic [63:0] a,
                            input logic [63:0] wd64, input logic [63:0] rsp,
                            input int rdy_dly, input int rsp_dly, input int fmode);
    int          nb;
    int          lane;
    int          mk;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_rd;
    logic [7:0]  e_mask;
    nb      = m_nbytes(wd);
    lane    = int'(a % 8);
    e_addr  = a - (a % 8);
    mk      = ((1 << nb) - 1) << lane;
    e_mask  = we ? mk[7:0] : 8'h00;
    e_wdata = wd64 << (8 * lane);
    e_rd    = we ? 64'd0 : m_load(wd, a, rsp);

    @(negedge clk);
    mem_valid = 1'b1; we_mem = we; memdata_width = wd; addr = a; wdata = wd64; resp_data = rsp;
    #1;
    n_checks++; if (stall_mem !== 1'b1) $display("FAIL idle_stall got=%b exp=1", stall_mem); else n_pass++;
    n_checks++; if (misalign_exc !== 1'b0) $display("FAIL idle_misalign got=%b exp=0", misalign_exc); else n_pass++;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL idle_req_valid got=%b exp=0", req_valid); else n_pass++;
    @(negedge clk);

    for (int i = 0; i <= rdy_dly; i++) begin
      mem_valid = 1'($urandom_range(0, 1));
      we_mem = 1'($urandom_range(0, 1));
      memdata_width = 3'($urandom);
      addr = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      req_ready = (i == rdy_dly);
      resp_valid = 1'($urandom_range(0, 1));
      flush = (fmode == 1) && (i == 0);
      #1;
      n_checks++; if (req_valid !== 1'b1) $display("FAIL req_valid got=%b exp=1 cyc=%0d", req_valid, i); else n_pass++;
      n_checks++; if (req_addr !== e_addr) $display("FAIL req_addr got=%h exp=%h", req_addr, e_addr); else n_pass++;
      n_checks++; if (req_we !== we) $display("FAIL req_we got=%b exp=%b", req_we, we); else n_pass++;
      n_checks++; if (req_wmask !== e_mask) $display("FAIL req_wmask got=%h exp=%h", req_wmask, e_mask); else n_pass++;
      if (we) begin
        n_checks++; if (req_wdata !== e_wdata) $display("FAIL req_wdata got=%h exp=%h", req_wdata, e_wdata); else n_pass++;
      end
      n_checks++; if (stall_mem !== 1'b1) $display("FAIL req_stall got=%b exp=1", stall_mem); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL req_done got=%b exp=0", done); else n_pass++;
      n_checks++; if (misalign_exc !== 1'b0) $display("FAIL req_misalign got=%b exp=0", misalign_exc); else n_pass++;
      @(negedge clk);
    end

    req_ready = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i <= rsp_dly; i++) begin
      resp_valid = (i == rsp_dly);
      flush = (fmode == 2) && (i == 0);
      #1;
      n_checks++; if (req_valid !== 1'b0) $display("FAIL wait_req_valid got=%b exp=0", req_valid); else n_pass++;
      n_checks++; if (stall_mem !== 1'b1) $display("FAIL wait_stall got=%b exp=1", stall_mem); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL wait_done got=%b exp=0", done); else n_pass++;
      @(negedge clk);
    end
    resp_valid = 1'b0; flush = 1'b0;
    #1;

    if (fmode != 0) begin
      n_checks++; if (done !== 1'b0) $display("FAIL drop_done got=%b exp=0", done); else n_pass++;
      n_checks++; if (rdata_out !== m_rdata) $display("FAIL drop_rdata got=%h exp=%h", rdata_out, m_rdata); else n_pass++;
    end else begin
      n_checks++; if (done !== 1'b1) $display("FAIL done got=%b exp=1", done); else n_pass++;
      n_checks++; if (rdata_out !== e_rd) $display("FAIL rdata got=%h exp=%h", rdata_out, e_rd); else n_pass++;
      m_rdata = e_rd;
    end
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL end_stall got=%b exp=0", stall_mem); else n_pass++;

    @(negedge clk);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", done); else n_pass++;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL after_req_valid got=%b exp=0", req_valid); else n_pass++;
    n_checks++; if (rdata_out !== m_rdata) $display("FAIL rdata_hold got=%h exp=%h", rdata_out, m_rdata); else n_pass++;
  endtask

  task automatic test_reset;
    rstn = 1'b0; mem_valid = 1'b1; memdata_width = 3'b010; addr = 64'h1002;
    #2;
    n_checks++; if (misalign_exc !== 1'b0) $display("FAIL rst_misalign got=%b exp=0", misalign_exc); else n_pass++;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall_mem); else n_pass++;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b exp=0", req_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (rdata_out !== 64'd0) $display("FAIL rst_rdata got=%h exp=0", rdata_out); else n_pass++;
    @(negedge clk);
    mem_valid = 1'b0; rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw_sign;
    run_access(3'b010, 1'b0, 64'h1004, 64'd0, 64'h80000000_12345678, 0, 0, 0);
    n_checks++; if (rdata_out !== 64'hFFFFFFFF_80000000) $display("FAIL lw_sign got=%h exp=ffffffff80000000", rdata_out); else n_pass++;
  endtask

  task automatic test_lbu;
    run_access(3'b111, 1'b0, 64'h1003, 64'd0, 64'h11223344_A5667788, 1, 1, 0);
    n_checks++; if (rdata_out !== 64'h00000000_000000A5) $display("FAIL lbu got=%h exp=a5", rdata_out); else n_pass++;
  endtask

  task automatic test_sh;
    run_access(3'b011, 1'b1, 64'h1006, 64'h0000_0000_0000_BEEF, 64'h1234, 0, 1, 0);
    n_checks++; if (rdata_out !== 64'd0) $display("FAIL store_rdata got=%h exp=0", rdata_out); else n_pass++;
  endtask

  task automatic test_ld_stall;
    run_access(3'b001, 1'b0, 64'h2000, 64'd0, 64'hDEADBEEF_CAFEF00D, 3, 2, 0);
  endtask

  task automatic test_flush;
    run_access(3'b010, 1'b0, 64'h1008, 64'd0, 64'h5555_6666_7777_8888, 1, 2, 2);
    run_access(3'b001, 1'b0, 64'h1010, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 1, 1);
  endtask

  task automatic test_misalign;
    logic [2:0]  wd;
    logic [63:0] a;
    int          nb;
    @(negedge clk);
    mem_valid = 1'b1; we_mem = 1'b0; memdata_width = 3'b010; addr = 64'h1002;
    #1;
    n_checks++; if (misalign_exc !== 1'b1) $display("FAIL mis_exc got=%b exp=1", misalign_exc); else n_pass++;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL mis_stall got=%b exp=0", stall_mem); else n_pass++;
    flush = 1'b1;
    #1;
    n_checks++; if (misalign_exc !== 1'b0) $display("FAIL mis_flush got=%b exp=0", misalign_exc); else n_pass++;
    @(negedge clk);
    addr = 64'h1000;
    #1;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL mis_no_req got=%b exp=0", req_valid); else n_pass++;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL flush_idle_stall got=%b exp=0", stall_mem); else n_pass++;
    @(negedge clk);
    mem_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL flush_no_capture got=%b exp=0", req_valid); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: wd = 3'b011;
        1: wd = 3'b110;
        2: wd = 3'b010;
        3: wd = 3'b101;
        default: wd = 3'b001;
      endcase
      nb = m_nbytes(wd);
      a = {$urandom, $urandom};
      a = a - (a % nb) + 64'(1 + $urandom_range(0, nb - 2));
      @(negedge clk);
      mem_valid = 1'b1; memdata_width = wd; addr = a; we_mem = (wd[2:1] != 2'b11) && 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (misalign_exc !== 1'b1) $display("FAIL mis_rand_exc got=%b exp=1 addr=%h", misalign_exc, a); else n_pass++;
      n_checks++; if (stall_mem !== 1'b0) $display("FAIL mis_rand_stall got=%b exp=0", stall_mem); else n_pass++;
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      n_checks++; if (req_valid !== 1'b0) $display("FAIL mis_rand_req got=%b exp=0", req_valid); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [2:0]  wd;
    logic        we;
    logic [63:0] a;
    int          nb;
    int          fm;
    int          rd;
    for (int k = 0; k < 30; k++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, we ? 3 : 6))
        0: wd = 3'b100;
        1: wd = 3'b011;
        2: wd = 3'b010;
        3: wd = 3'b001;
        4: wd = 3'b111;
        5: wd = 3'b110;
        default: wd = 3'b101;
      endcase
      nb = m_nbytes(wd);
      a = {$urandom, $urandom};
      a = a - (a % nb);
      fm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      rd = (fm == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      run_access(wd, we, a, {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(0, 3)), rd, fm);
    end
  endtask

  task automatic test_reset_mid;
    run_access(3'b100, 1'b0, 64'h1007, 64'd0, 64'hF0FF_FFFF_FFFF_FFFF, 0, 0, 0);
    @(negedge clk);
    mem_valid = 1'b1; we_mem = 1'b0; memdata_width = 3'b001; addr = 64'h3000;
    @(negedge clk);
    mem_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    m_rdata = 64'd0;
    n_checks++; if (rdata_out !== 64'd0) $display("FAIL midrst_rdata got=%h exp=0", rdata_out); else n_pass++;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", stall_mem); else n_pass++;
    n_checks++; if (req_valid !== 1'b0) $display("FAIL midrst_req got=%b exp=0", req_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", done); else n_pass++;
    @(negedge clk);
    rstn = 1'b1; resp_valid = 1'b1; resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    n_checks++; if (stall_mem !== 1'b0) $display("FAIL postrst_stall got=%b exp=0", stall_mem); else n_pass++;
    @(negedge clk);
    resp_valid = 1'b0;
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL postrst_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (rdata_out !== m_rdata) $display("FAIL postrst_rdata got=%h exp=%h", rdata_out, m_rdata); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_sign();
    test_lbu();
    test_sh();
    test_ld_stall();
    test_flush();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
